// File: rtl/bus_memoria_ctrl_if.sv
// Core-side request/response handshake of the CPUCR memory bus master.
// The controller uses the slave modport; the CPU core (or a bench) uses master.
interface bus_memoria_ctrl_if;
    logic        req;
    logic        we;
    logic        word;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;
    logic        busy;

    modport slave (
        input  req,
        input  we,
        input  word,
        input  addr,
        input  wdata,
        output rdata,
        output ack,
        output busy
    );

    modport master (
        output req,
        output we,
        output word,
        output addr,
        output wdata,
        input  rdata,
        input  ack,
        input  busy
    );
endinterface

// File: rtl/bus_memoria_ctrl.sv
// Bus master for the CPUCR main-memory bus: turns single-cycle core requests into
// timed byte cycles on Direccion/Datos/LE (big-endian words, write on LE fall).
module bus_memoria_ctrl #(
    parameter int READ_WAIT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    bus_memoria_ctrl_if.slave  core,
    output logic [15:0]        Direccion,
    inout  wire  [7:0]         Datos,
    output logic               LE
);

    localparam int WW = (READ_WAIT < 2) ? 1 : $clog2(READ_WAIT + 1);
    // The first byte of a read gets one extra settle cycle after the address goes out.
    localparam logic [WW-1:0] WAIT_FIRST = WW'(READ_WAIT);
    localparam logic [WW-1:0] WAIT_NEXT  = WW'(READ_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WSETUP,
        WSTROBE,
        WHOLD,
        DONE
    } state_t;

    state_t          state_reg, state_next;
    logic            we_reg, we_next;
    logic            word_reg, word_next;
    logic            bi_reg, bi_next;
    logic [15:0]     addr_reg, addr_next;
    logic [15:0]     wdata_reg, wdata_next;
    logic [15:0]     rdata_reg, rdata_next;
    logic [WW-1:0]   wait_reg, wait_next;
    logic [15:0]     dir_reg, dir_next;
    logic [7:0]      dout_reg, dout_next;
    logic            drive_reg, drive_next;
    logic            le_reg, le_next;
    logic            ack_reg, ack_next;
    logic            busy_reg, busy_next;
    logic [15:0]     byte_addr_next;
    logic [7:0]      byte_data_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            word_reg  <= 1'b0;
            bi_reg    <= 1'b0;
            addr_reg  <= 16'h0000;
            wdata_reg <= 16'h0000;
            rdata_reg <= 16'h0000;
            wait_reg  <= '0;
            dir_reg   <= 16'h0000;
            dout_reg  <= 8'h00;
            drive_reg <= 1'b0;
            le_reg    <= 1'b1;
            ack_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            we_reg    <= we_next;
            word_reg  <= word_next;
            bi_reg    <= bi_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            wait_reg  <= wait_next;
            dir_reg   <= dir_next;
            dout_reg  <= dout_next;
            drive_reg <= drive_next;
            le_reg    <= le_next;
            ack_reg   <= ack_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        we_next    = we_reg;
        word_next  = word_reg;
        bi_next    = bi_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        wait_next  = wait_reg;

        case (state_reg)
            IDLE: begin
                if (core.req) begin
                    we_next    = core.we;
                    word_next  = core.word;
                    addr_next  = core.addr;
                    wdata_next = core.wdata;
                    bi_next    = 1'b0;
                    wait_next  = WAIT_FIRST;
                    state_next = core.we ? WSETUP : RD;
                end
            end
            RD: begin
                if (wait_reg != '0) begin
                    wait_next = wait_reg - 1'b1;
                end else begin
                    if (!word_reg) begin
                        rdata_next = {8'h00, Datos};
                    end else if (!bi_reg) begin
                        rdata_next[15:8] = Datos;
                    end else begin
                        rdata_next[7:0] = Datos;
                    end
                    if (word_reg && !bi_reg) begin
                        bi_next   = 1'b1;
                        wait_next = WAIT_NEXT;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            WSETUP:  state_next = WSTROBE;
            WSTROBE: state_next = WHOLD;
            WHOLD: begin
                if (word_reg && !bi_reg) begin
                    bi_next    = 1'b1;
                    state_next = WSETUP;
                end else begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        byte_addr_next = addr_next + {15'd0, bi_next};
        byte_data_next = (word_next && !bi_next) ? wdata_next[15:8] : wdata_next[7:0];

        dir_next   = dir_reg;
        dout_next  = dout_reg;
        if (state_next == RD || state_next == WSETUP) begin
            dir_next = byte_addr_next;
        end
        if (state_next == WSETUP) begin
            dout_next = byte_data_next;
        end

        drive_next = (state_next == WSETUP) || (state_next == WSTROBE) || (state_next == WHOLD);
        le_next    = (state_next != WSTROBE);
        ack_next   = (state_next == DONE);
        busy_next  = (state_next != IDLE);
    end

    assign Direccion  = dir_reg;
    assign LE         = le_reg;
    assign Datos      = drive_reg ? dout_reg : 8'bz;
    assign core.rdata = rdata_reg;
    assign core.ack   = ack_reg;
    assign core.busy  = busy_reg;

endmodule

// File: tb/tb_bus_memoria_ctrl.sv
// Scoreboard bench for bus_memoria_ctrl: two instances (READ_WAIT=1 and 3), each
// with a behavioural byte memory on Direccion/Datos/LE and an ack-driven monitor.
module tb_bus_memoria_ctrl;

    typedef struct {
        bit          is_read;
        logic [15:0] rdata;
        int          lat;
        int          c0;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n1, rst_n3;
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   le_low1;
    bit   rd_active1, rd_active3;

    exp_t q1[$];
    exp_t q3[$];

    logic [15:0] dir1, dir3;
    wire  [7:0]  datos1, datos3;
    logic        le1, le3;
    logic [7:0]  mem1 [0:65535];
    logic [7:0]  mem3 [0:65535];

    bus_memoria_ctrl_if core1();
    bus_memoria_ctrl_if core3();

    bus_memoria_ctrl #(.READ_WAIT(1)) dut1 (
        .clk       (clk),
        .reset_n   (rst_n1),
        .core      (core1),
        .Direccion (dir1),
        .Datos     (datos1),
        .LE        (le1)
    );

    bus_memoria_ctrl #(.READ_WAIT(3)) dut3 (
        .clk       (clk),
        .reset_n   (rst_n3),
        .core      (core3),
        .Direccion (dir3),
        .Datos     (datos3),
        .LE        (le3)
    );

    // Memory model: combinational read while LE=1, write on LE falling edge.
    assign datos1 = (le1 && rd_active1) ? mem1[dir1] : 8'bz;
    assign datos3 = (le3 && rd_active3) ? mem3[dir3] : 8'bz;

    initial forever begin
        @(negedge le1);
        mem1[dir1] = datos1;
    end

    initial forever begin
        @(negedge le3);
        mem3[dir3] = datos3;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        le_low1 = 0;
        forever begin
            @(negedge clk);
            if (!le1) le_low1 = le_low1 + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: %h", name, act);
        end
    endtask

    // Monitors: every ack pops one expectation and checks latency and read data.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (core1.ack) begin
                if (q1.size() == 0) begin
                    check("dut1_spurious_ack", 32'(core1.ack), 32'(0));
                end else begin
                    e = q1.pop_front();
                    check({e.name, "_lat"}, 32'(cyc - e.c0), 32'(e.lat));
                    if (e.is_read) check({e.name, "_rdata"}, 32'(core1.rdata), 32'(e.rdata));
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (core3.ack) begin
                if (q3.size() == 0) begin
                    check("dut3_spurious_ack", 32'(core3.ack), 32'(0));
                end else begin
                    e = q3.pop_front();
                    check({e.name, "_lat"}, 32'(cyc - e.c0), 32'(e.lat));
                    if (e.is_read) check({e.name, "_rdata"}, 32'(core3.rdata), 32'(e.rdata));
                end
            end
        end
    end

    function automatic int qsize(input int d);
        return (d == 1) ? q1.size() : q3.size();
    endfunction

    task automatic wait_idle(input int d, input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (qsize(d) == 0) break;
        end
        if (qsize(d) != 0) begin
            check({name, "_timeout_pending"}, 32'(qsize(d)), 32'(0));
            if (d == 1) q1.delete(); else q3.delete();
        end
        if (d == 1) rd_active1 = 1'b0; else rd_active3 = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input int d, input bit is_read, input logic [15:0] rd,
                        input int lat, input string name);
        exp_t e;
        e.is_read = is_read;
        e.rdata   = rd;
        e.lat     = lat;
        e.c0      = cyc;
        e.name    = name;
        if (d == 1) q1.push_back(e); else q3.push_back(e);
    endtask

    task automatic issue(input int d, input bit we, input bit word, input logic [15:0] a,
                         input logic [15:0] wd, input logic [15:0] exp_rd, input int lat,
                         input string name);
        @(negedge clk);
        if (d == 1) begin
            rd_active1 = !we;
            core1.req = 1'b1; core1.we = we; core1.word = word;
            core1.addr = a; core1.wdata = wd;
        end else begin
            rd_active3 = !we;
            core3.req = 1'b1; core3.we = we; core3.word = word;
            core3.addr = a; core3.wdata = wd;
        end
        @(posedge clk);
        #1;
        push(d, !we, exp_rd, lat, name);
        // Scramble inputs after accept: the transaction must use latched values.
        if (d == 1) begin
            core1.req = 1'b0; core1.we = ~we; core1.word = ~word;
            core1.addr = ~a; core1.wdata = ~wd;
        end else begin
            core3.req = 1'b0; core3.we = ~we; core3.word = ~word;
            core3.addr = ~a; core3.wdata = ~wd;
        end
        wait_idle(d, name);
    endtask

    initial begin
        int          le_before;
        logic [7:0]  pre5;

        n_tests = 0;
        n_fail  = 0;
        rd_active1 = 1'b0;
        rd_active3 = 1'b0;
        core1.req = 1'b0; core1.we = 1'b0; core1.word = 1'b0; core1.addr = 16'h0; core1.wdata = 16'h0;
        core3.req = 1'b0; core3.we = 1'b0; core3.word = 1'b0; core3.addr = 16'h0; core3.wdata = 16'h0;
        rst_n1 = 1'b1;
        rst_n3 = 1'b1;
        #1;
        rst_n1 = 1'b0;
        rst_n3 = 1'b0;
        #1;
        check("por_le", 32'(le1), 32'(1));
        check("por_dir", 32'(dir1), 32'(16'h0000));
        check("por_ack", 32'(core1.ack), 32'(0));
        check("por_busy", 32'(core1.busy), 32'(0));
        check("por_rdata", 32'(core1.rdata), 32'(16'h0000));
        repeat (2) @(negedge clk);
        rst_n1 = 1'b1;
        rst_n3 = 1'b1;
        @(negedge clk);

        // Reset in the middle of a word write (dut1 sits in WSTROBE after E1).
        core1.req = 1'b1; core1.we = 1'b1; core1.word = 1'b1;
        core1.addr = 16'h0030; core1.wdata = 16'h7777;
        @(posedge clk); #1;
        core1.req = 1'b0;
        @(posedge clk); #1;
        check("midrun_le_strobe", 32'(le1), 32'(0));
        check("midrun_busy_before", 32'(core1.busy), 32'(1));
        rst_n1 = 1'b0;
        #1;
        check("midrun_rst_le", 32'(le1), 32'(1));
        check("midrun_rst_dir", 32'(dir1), 32'(16'h0000));
        check("midrun_rst_ack", 32'(core1.ack), 32'(0));
        check("midrun_rst_busy", 32'(core1.busy), 32'(0));
        repeat (2) @(negedge clk);
        rst_n1 = 1'b1;
        repeat (2) @(negedge clk);

        // Byte write / byte read.
        le_before = le_low1;
        issue(1, 1'b1, 1'b0, 16'h0010, 16'h00A5, 16'h0000, 3, "bw_0010");
        check("bw_0010_le_low_cycles", 32'(le_low1 - le_before), 32'(1));
        check("bw_0010_mem", 32'(mem1[16'h0010]), 32'(8'hA5));
        issue(1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h00A5, 2, "br_0010");

        // Word write / word read, big-endian.
        issue(1, 1'b1, 1'b1, 16'h0002, 16'h1234, 16'h0000, 6, "ww_0002");
        check("ww_0002_mem_hi", 32'(mem1[16'h0002]), 32'(8'h12));
        check("ww_0002_mem_lo", 32'(mem1[16'h0003]), 32'(8'h34));
        issue(1, 1'b0, 1'b1, 16'h0002, 16'h0000, 16'h1234, 3, "wr_0002");

        // Word at FFFF wraps its second byte to 0000.
        issue(1, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 6, "ww_ffff");
        check("ww_ffff_mem_hi", 32'(mem1[16'hFFFF]), 32'(8'hBE));
        check("ww_ffff_mem_lo", 32'(mem1[16'h0000]), 32'(8'hEF));
        issue(1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hBEEF, 3, "wr_ffff");

        // req held high across a byte read with addr changed after accept.
        issue(1, 1'b1, 1'b0, 16'h0020, 16'h005A, 16'h0000, 3, "bw_0020");
        @(negedge clk);
        rd_active1 = 1'b1;
        core1.req = 1'b1; core1.we = 1'b0; core1.word = 1'b0; core1.addr = 16'h0010;
        @(posedge clk); #1;
        push(1, 1'b1, 16'h00A5, 2, "held_rd_0010");
        core1.addr = 16'h0020;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("held_idle_gap_busy", 32'(core1.busy), 32'(0));
        @(posedge clk); #1;
        push(1, 1'b1, 16'h005A, 2, "held_rd_0020");
        core1.req = 1'b0;
        check("held_reaccept_busy", 32'(core1.busy), 32'(1));
        wait_idle(1, "held");

        // READ_WAIT=3 instance.
        issue(3, 1'b1, 1'b1, 16'h0002, 16'h1234, 16'h0000, 6, "rw3_ww_0002");
        issue(3, 1'b0, 1'b1, 16'h0002, 16'h0000, 16'h1234, 7, "rw3_wr_0002");

        // Reset during WSTROBE of byte 0: only the high byte lands, no ack.
        pre5 = mem3[16'h0005];
        @(negedge clk);
        core3.req = 1'b1; core3.we = 1'b1; core3.word = 1'b1;
        core3.addr = 16'h0004; core3.wdata = 16'hC3D4;
        @(posedge clk); #1;
        core3.req = 1'b0;
        @(posedge clk); #1;
        check("rst_strobe_le_low", 32'(le3), 32'(0));
        rst_n3 = 1'b0;
        #1;
        check("rst_strobe_le", 32'(le3), 32'(1));
        check("rst_strobe_busy", 32'(core3.busy), 32'(0));
        check("rst_strobe_dir", 32'(dir3), 32'(16'h0000));
        repeat (2) @(negedge clk);
        rst_n3 = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_strobe_mem_hi", 32'(mem3[16'h0004]), 32'(8'hC3));
        check("rst_strobe_mem_lo", 32'(mem3[16'h0005]), 32'(pre5));
        check("rst_strobe_idle", 32'(core3.busy), 32'(0));

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
